// File: rtl/posit_mul_scheduler_if.sv
// Requester-side handshake bundle for posit_mul_scheduler: operand request channel and result response channel.
interface posit_mul_scheduler_if #(
  parameter int N = 8
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [1:0]     resp_valid;
  logic [1:0]     resp_ready;
  logic [N-1:0]   resp_data;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/posit_mul_scheduler.sv
// Round-robin two-requester sequencer for one shared combinational posit multiplier.
// Optional feature macro POSIT_MUL_BYPASS_EN: zero/NaR operands skip the multiplier cycle.
module posit_mul_scheduler #(
  parameter int N     = 8,
  parameter int ES    = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  posit_mul_scheduler_if.slave bus,
  output logic [N-1:0]         mul_a,
  output logic [N-1:0]         mul_b,
  input  logic [N-1:0]         mul_out,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  if (ES >= N) begin : g_bad_es
    $error("posit_mul_scheduler: ES must be smaller than N");
  end

  state_e           state_q;
  logic             prio_q;
  logic             owner_q;
  logic [N-1:0]     opa_q;
  logic [N-1:0]     opb_q;
  logic [N-1:0]     res_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             gnt_any;
  logic             gnt_idx;
  logic             accept;
  logic             resp_hs;
  logic [N-1:0]     acc_a;
  logic [N-1:0]     acc_b;

  // Lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    gnt_any = |bus.req_valid;
    gnt_idx = 1'b0;
    case (bus.req_valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = prio_q;
      default: gnt_idx = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && gnt_any && !rst;
  assign acc_a  = gnt_idx ? bus.req_a[2*N-1:N] : bus.req_a[N-1:0];
  assign acc_b  = gnt_idx ? bus.req_b[2*N-1:N] : bus.req_b[N-1:0];

  assign bus.req_ready = accept ? (2'b01 << gnt_idx) : 2'b00;

  assign resp_hs = (state_q == RESP) && bus.resp_ready[owner_q];
  assign cnt_d   = cnt_q + CNT_W'(1);

  assign bus.resp_valid = (state_q == RESP) ? (2'b01 << owner_q) : 2'b00;
  assign bus.resp_data  = res_q;
  assign mul_a          = opa_q;
  assign mul_b          = opb_q;
  assign busy           = (state_q != IDLE);
  assign op_count       = cnt_q;

`ifdef POSIT_MUL_BYPASS_EN
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  function automatic logic is_nar(input logic [N-1:0] p);
    return p == NAR;
  endfunction

  function automatic logic is_zero(input logic [N-1:0] p);
    return p == '0;
  endfunction

  logic byp_nar;
  logic byp;

  // NaR dominates zero: 0 x NaR is NaR.
  assign byp_nar = is_nar(acc_a) || is_nar(acc_b);
  assign byp     = byp_nar || is_zero(acc_a) || is_zero(acc_b);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= gnt_idx;
            prio_q  <= ~gnt_idx;
`ifdef POSIT_MUL_BYPASS_EN
            if (byp) begin
              res_q   <= byp_nar ? NAR : '0;
              state_q <= RESP;
            end else begin
              opa_q   <= acc_a;
              opb_q   <= acc_b;
              state_q <= EXEC;
            end
`else
            opa_q   <= acc_a;
            opb_q   <= acc_b;
            state_q <= EXEC;
`endif
          end
        end
        EXEC: begin
          res_q   <= mul_out;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_hs) begin
            cnt_q   <= cnt_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_mul_scheduler.sv
// Bench for posit_mul_scheduler: table vectors, arbitration/stall/reset sequences, per-requester result scoreboards.
module tb_posit_mul_scheduler;
  localparam int N     = 8;
  localparam int CNT_W = 16;

  typedef struct {
    int         rq;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } job_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     mul_a;
  logic [N-1:0]     mul_b;
  logic [N-1:0]     mul_out;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  bit   [1:0]       drv_valid = 2'b00;
  logic [2*N-1:0]   drv_a = '0;
  logic [2*N-1:0]   drv_b = '0;
  bit   [1:0]       rr = 2'b11;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  job_t       jobs0[$];
  job_t       jobs1[$];
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  int         grant_log[$];
  int         acc_cyc[$];
  bit   [1:0] pres = 2'b00;
  bit   [1:0] acc = 2'b00;
  logic [7:0] pend[2];
  vec_t       tbl[8];

  posit_mul_scheduler_if #(.N(N)) bus ();

  assign bus.req_valid  = drv_valid;
  assign bus.req_a      = drv_a;
  assign bus.req_b      = drv_b;
  assign bus.resp_ready = rr;

  posit_mul_scheduler #(.N(N), .ES(4), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_out  (mul_out),
    .busy     (busy),
    .op_count (op_count)
  );

  // Stand-in multiplier: exact for regime-0, fraction-free posits (exponents add);
  // anything else gets an arbitrary asymmetric value, since the scheduler only routes it.
  function automatic logic [7:0] mul_model(input logic [7:0] a, input logic [7:0] b);
    logic [4:0] e;
    e = {1'b0, a[4:1]} + {1'b0, b[4:1]};
    if (a[7:5] == 3'b010 && b[7:5] == 3'b010 && !a[0] && !b[0] && !e[4])
      return {3'b010, e[3:0], 1'b0};
    return (a + {b[6:0], 1'b0}) ^ 8'h5A;
  endfunction

  assign mul_out = mul_model(mul_a, mul_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event seen/missing, required the opposite", nm);
  endtask

  // Requester drivers act on the falling edge; handshakes are observed 2 time units later.
  always @(negedge clk) begin
    job_t j;
    for (int i = 0; i < 2; i++) begin
      if (pres[i] && acc[i]) begin
        pres[i]      = 1'b0;
        drv_valid[i] = 1'b0;
      end
    end
    if (!pres[0] && jobs0.size() > 0) begin
      j = jobs0.pop_front();
      drv_a[7:0] = j.a; drv_b[7:0] = j.b; pend[0] = j.exp;
      drv_valid[0] = 1'b1; pres[0] = 1'b1;
    end
    if (!pres[1] && jobs1.size() > 0) begin
      j = jobs1.pop_front();
      drv_a[15:8] = j.a; drv_b[15:8] = j.b; pend[1] = j.exp;
      drv_valid[1] = 1'b1; pres[1] = 1'b1;
    end
    acc = 2'b00;
    #2;
    if (rst) begin
      sb0.delete();
      sb1.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc[i] = 1'b1;
          grant_log.push_back(i);
          acc_cyc.push_back(cyc);
          if (i == 0) sb0.push_back(pend[0]);
          else        sb1.push_back(pend[1]);
        end
      end
      if (bus.resp_valid[0] && bus.resp_ready[0]) begin
        if (sb0.size() == 0) fail_msg("resp0_unexpected");
        else chk("resp0_data", bus.resp_data, sb0.pop_front());
      end
      if (bus.resp_valid[1] && bus.resp_ready[1]) begin
        if (sb1.size() == 0) fail_msg("resp1_unexpected");
        else chk("resp1_data", bus.resp_data, sb1.pop_front());
      end
    end
  end

  task automatic push_job(input int rq, input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    job_t j;
    j.a = a; j.b = b; j.exp = exp;
    if (rq == 0) jobs0.push_back(j);
    else         jobs1.push_back(j);
  endtask

  task automatic wait_idle(input string nm);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk); #3;
      if (jobs0.size() == 0 && jobs1.size() == 0 && pres == 2'b00 &&
          sb0.size() == 0 && sb1.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) fail_msg({nm, "_timeout"});
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 8'h40, 8'h40, 8'h40};
    tbl[1] = '{1, 8'h42, 8'h42, 8'h44};
    tbl[2] = '{0, 8'h40, 8'h42, 8'h42};
    tbl[3] = '{1, 8'h44, 8'h46, 8'h4A};
    tbl[4] = '{0, 8'h48, 8'h42, 8'h4A};
    tbl[5] = '{1, 8'h50, 8'h4E, 8'h5E};
    tbl[6] = '{0, 8'h5E, 8'h40, 8'h5E};
    tbl[7] = '{1, 8'h42, 8'h4C, 8'h4E};

    // Reset values, then first lone request and its latency.
    push_job(0, 8'h40, 8'h40, 8'h40);
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_resp_valid", bus.resp_valid, 2'b00);
    chk("rst_resp_data", bus.resp_data, 8'h00);
    chk("rst_mul_a", mul_a, 8'h00);
    chk("rst_mul_b", mul_b, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_op_count", op_count, 16'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("t1_req_ready", bus.req_ready, 2'b01);
    @(negedge clk); #1;
    chk("t1_exec_busy", busy, 1'b1);
    chk("t1_exec_resp_valid", bus.resp_valid, 2'b00);
    chk("t1_exec_mul_a", mul_a, 8'h40);
    chk("t1_exec_mul_b", mul_b, 8'h40);
    @(negedge clk); #1;
    chk("t1_resp_valid", bus.resp_valid, 2'b01);
    chk("t1_resp_data", bus.resp_data, 8'h40);
    @(negedge clk); #1;
    chk("t1_op_count", op_count, 16'd1);
    chk("t1_busy_after", busy, 1'b0);
    wait_idle("t1");

    // Table vectors, one lone request at a time.
    for (int i = 0; i < 8; i++) begin
      push_job(tbl[i].rq, tbl[i].a, tbl[i].b, tbl[i].exp);
      wait_idle("tbl");
    end
    chk("tbl_op_count", op_count, 16'd9);

    // Both valid from reset: req0 first, accepts 3 cycles apart.
    grant_log.delete(); acc_cyc.delete();
    push_job(0, 8'h42, 8'h42, 8'h44);
    push_job(1, 8'h40, 8'h42, 8'h42);
    do_reset();
    wait_idle("t2");
    if (grant_log.size() != 2) fail_msg("t2_grant_count");
    else begin
      chk("t2_grant0", grant_log[0], 0);
      chk("t2_grant1", grant_log[1], 1);
      chk("t2_interval", acc_cyc[1] - acc_cyc[0], 3);
    end

    // Continuous contention: six alternating grants at the minimum interval.
    grant_log.delete(); acc_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 2; r++) begin
        logic [7:0] a, b;
        a = 8'($urandom);
        b = 8'($urandom);
        push_job(r, a, b, mul_model(a, b));
      end
    end
    do_reset();
    wait_idle("t3");
    chk("t3_op_count", op_count, 16'd6);
    if (grant_log.size() != 6) fail_msg("t3_grant_count");
    else begin
      for (int k = 0; k < 6; k++) chk("t3_grant", grant_log[k], k % 2);
      for (int k = 1; k < 6; k++) chk("t3_interval", acc_cyc[k] - acc_cyc[k-1], 3);
    end

    // Response stall on req0 while req1 waits; req1's resp_ready must be ignored.
    rr = 2'b10;
    push_job(0, 8'h44, 8'h46, 8'h4A);
    push_job(1, 8'h48, 8'h42, 8'h4A);
    do_reset();
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk); #1;
        if (bus.resp_valid != 2'b00) seen = 1'b1;
      end
      if (!seen) fail_msg("t4_resp_timeout");
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk("t4_resp_valid", bus.resp_valid, 2'b01);
      chk("t4_resp_data", bus.resp_data, 8'h4A);
      chk("t4_req_ready", bus.req_ready, 2'b00);
      chk("t4_mul_a", mul_a, 8'h44);
      chk("t4_mul_b", mul_b, 8'h46);
    end
    @(negedge clk); rr = 2'b11;
    @(negedge clk); #1;
    chk("t4_req1_ready", bus.req_ready, 2'b10);
    chk("t4_op_count", op_count, 16'd1);
    wait_idle("t4");

    // Reset during EXEC drops the transaction and clears the pointer.
    push_job(0, 8'h40, 8'h40, 8'h40);
    do_reset();
    @(negedge clk); #1;
    chk("t5_exec_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t5_resp_valid", bus.resp_valid, 2'b00);
      chk("t5_op_count", op_count, 16'd0);
    end
    grant_log.delete();
    push_job(0, 8'h42, 8'h42, 8'h44);
    push_job(1, 8'h40, 8'h42, 8'h42);
    wait_idle("t5_pair");
    if (grant_log.size() != 2) fail_msg("t5_grant_count");
    else chk("t5_prio_after_rst", grant_log[0], 0);
    grant_log.delete();
    push_job(1, 8'h44, 8'h44, 8'h48);
    wait_idle("t5_lone1");
    if (grant_log.size() != 1) fail_msg("t5_lone_count");
    else chk("t5_lone_grant", grant_log[0], 1);
    chk("t5_op_count_end", op_count, 16'd3);

`ifdef POSIT_MUL_BYPASS_EN
    // Special operands go straight to RESP; the multiplier operands never move.
    push_job(0, 8'h80, 8'h42, 8'h80);
    do_reset();
    @(negedge clk); #1;
    chk("byp_nar_resp_valid", bus.resp_valid, 2'b01);
    chk("byp_nar_resp_data", bus.resp_data, 8'h80);
    chk("byp_nar_mul_a", mul_a, 8'h00);
    chk("byp_nar_mul_b", mul_b, 8'h00);
    wait_idle("byp_nar");
    push_job(0, 8'h00, 8'h44, 8'h00);
    @(negedge clk); #1;
    chk("byp_zero_ready", bus.req_ready, 2'b01);
    @(negedge clk); #1;
    chk("byp_zero_resp_valid", bus.resp_valid, 2'b01);
    chk("byp_zero_resp_data", bus.resp_data, 8'h00);
    chk("byp_zero_mul_a", mul_a, 8'h00);
    chk("byp_zero_mul_b", mul_b, 8'h00);
    wait_idle("byp_zero");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
